// File: rtl/axil_arb_wr.sv
// rtl/axil_arb_wr.sv - AXI-Lite write-path fixed-priority arbiter and slave-select decoder (optional watchdog: AXIL_ARB_WR_TIMEOUT_EN)
module axil_arb_wr #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter int                        TIMEOUT_CYCLES = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [AXI_ADDR_WIDTH-1:0] m_axil_awaddr_0,
    input  logic                      m_axil_awvalid_0,
    input  logic                      m_axil_wvalid_0,
    input  logic                      m_axil_bready_0,
    input  logic [AXI_ADDR_WIDTH-1:0] m_axil_awaddr_1,
    input  logic                      m_axil_awvalid_1,
    input  logic                      m_axil_wvalid_1,
    input  logic                      m_axil_bready_1,
    input  logic                      mux_awready,
    input  logic                      mux_wready,
    input  logic                      mux_bvalid,
    output logic [1:0]                grant,
    output logic                      slv_invalid,
    output logic                      busy,
    output logic                      wr_timeout
);

    typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

    state_t                    state, state_nxt;
    logic                      aw_done, w_done;
    logic                      g_awvalid, g_wvalid, g_bready;
    logic                      aw_all, w_all, b_hs, any_req, expire;
    logic [AXI_ADDR_WIDTH-1:0] req_addr;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axil_arb_wr: TIMEOUT_CYCLES must be at least 2");
    end

    // Handshake qualifiers follow only the granted master.
    assign g_awvalid = (grant[0] & m_axil_awvalid_0) | (grant[1] & m_axil_awvalid_1);
    assign g_wvalid  = (grant[0] & m_axil_wvalid_0)  | (grant[1] & m_axil_wvalid_1);
    assign g_bready  = (grant[0] & m_axil_bready_0)  | (grant[1] & m_axil_bready_1);

    assign aw_all   = aw_done | (mux_awready & g_awvalid);
    assign w_all    = w_done  | (mux_wready  & g_wvalid);
    assign b_hs     = (state == RESP) & mux_bvalid & g_bready;
    assign any_req  = m_axil_awvalid_0 | m_axil_awvalid_1;
    assign req_addr = m_axil_awvalid_0 ? m_axil_awaddr_0 : m_axil_awaddr_1;

`ifdef AXIL_ARB_WR_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;

    // A B handshake landing in the expiry cycle wins over the watchdog.
    assign expire = (state != IDLE) && (to_cnt == CNT_LAST) && !b_hs;

    always_ff @(posedge aclk) begin
        if (areset || state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_timeout <= 1'b0;
        end else begin
            wr_timeout <= expire;
        end
    end
`else
    assign expire     = 1'b0;
    assign wr_timeout = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (any_req)        state_nxt = ADDR_DATA;
            ADDR_DATA: if (aw_all & w_all) state_nxt = RESP;
            RESP:      if (b_hs)           state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
        if (expire) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Grant and slave select are captured together and held until B or expiry.
    always_ff @(posedge aclk) begin
        if (areset) begin
            grant       <= 2'b00;
            slv_invalid <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (any_req) begin
                        grant       <= m_axil_awvalid_0 ? 2'b01 : 2'b10;
                        slv_invalid <= ((req_addr & ADDR_MASK) != (BASE_ADDR & ADDR_MASK));
                    end
                end
                ADDR_DATA: begin
                    aw_done <= aw_all;
                    w_done  <= w_all;
                end
                RESP: begin
                    if (b_hs) begin
                        grant   <= 2'b00;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: begin
                    grant   <= 2'b00;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
            endcase
            if (expire) begin
                grant   <= 2'b00;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

endmodule
